// File: rtl/seq_mul_pkg.sv
// Shared types and op decode helpers for the iterative RV32M multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // MUL only needs the low word, which is sign-agnostic, so it runs unsigned.
  function automatic logic op_signed1(mul_op_e op);
    return (op == MUL_HSS) || (op == MUL_HSU);
  endfunction

  function automatic logic op_signed2(mul_op_e op);
    return (op == MUL_HSS);
  endfunction

endpackage

// File: rtl/mul_step_add.sv
// One CALC step: STEP_BITS x XLEN partial product, shifted into place and added
// to the 2*XLEN accumulator.
module mul_step_add #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STEP_BITS = 1,
  localparam int unsigned SH_W     = $clog2(2 * XLEN)
) (
  input  logic [2*XLEN-1:0]    i_acc,
  input  logic [XLEN-1:0]      i_mcand,
  input  logic [STEP_BITS-1:0] i_bits,
  input  logic [SH_W-1:0]      i_shamt,
  output logic [2*XLEN-1:0]    o_sum
);

  localparam int unsigned PP_W = XLEN + STEP_BITS;

  logic [PP_W-1:0]   w_pp;
  logic [2*XLEN-1:0] w_pp_ext;

  assign w_pp     = {{STEP_BITS{1'b0}}, i_mcand} * {{XLEN{1'b0}}, i_bits};
  assign w_pp_ext = (2 * XLEN)'(w_pp);
  assign o_sum    = i_acc + (w_pp_ext << i_shamt);

endmodule

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU with start/busy/done.
// Define SEQ_MUL_EARLY_EXIT_EN to leave CALC once the remaining multiplier is zero.
module seq_mul_unit
  import seq_mul_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STEP_BITS = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_operand1,
  input  logic [XLEN-1:0] i_operand2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned N     = XLEN / STEP_BITS;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned SH_W  = $clog2(2 * XLEN);

  if (!((STEP_BITS == 1) || (STEP_BITS == 2) || (STEP_BITS == 4) || (STEP_BITS == 8)) ||
      ((XLEN % STEP_BITS) != 0)) begin : g_bad_step
    $error("seq_mul_unit: STEP_BITS must be 1, 2, 4 or 8 and divide XLEN");
  end

  state_e            r_state, w_state_d;
  mul_op_e           r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  mul_op_e           w_op_in;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic [XLEN-1:0]   w_mplier_nxt;
  logic [SH_W-1:0]   w_shamt;
  logic [2*XLEN-1:0] w_acc_sum;
  logic [2*XLEN-1:0] w_fixed;
  logic [XLEN-1:0]   w_res;
  logic              w_last;

  assign w_op_in = mul_op_e'(i_op);
  assign w_neg1  = op_signed1(w_op_in) & i_operand1[XLEN-1];
  assign w_neg2  = op_signed2(w_op_in) & i_operand2[XLEN-1];
  // Magnitude of the most negative value wraps to itself, which is correct unsigned.
  assign w_mag1  = w_neg1 ? (~i_operand1 + 1'b1) : i_operand1;
  assign w_mag2  = w_neg2 ? (~i_operand2 + 1'b1) : i_operand2;

  assign w_mplier_nxt = r_mplier >> STEP_BITS;
  assign w_shamt      = SH_W'(r_cnt * STEP_BITS);

  mul_step_add #(
    .XLEN     (XLEN),
    .STEP_BITS(STEP_BITS)
  ) u_step (
    .i_acc  (r_acc),
    .i_mcand(r_mcand),
    .i_bits (r_mplier[STEP_BITS-1:0]),
    .i_shamt(w_shamt),
    .o_sum  (w_acc_sum)
  );

`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign w_last = (r_cnt == CNT_W'(N - 1)) || (w_mplier_nxt == '0);
`else
  assign w_last = (r_cnt == CNT_W'(N - 1));
`endif

  assign w_fixed = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_res   = (r_op == MUL_LO) ? w_fixed[XLEN-1:0] : w_fixed[2*XLEN-1:XLEN];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_d = S_CALC;
      S_CALC:  if (w_last) w_state_d = S_FIX;
      S_FIX:   w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op     <= MUL_LO;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op     <= w_op_in;
            r_neg    <= w_neg1 ^ w_neg2;
            r_mcand  <= w_mag1;
            r_mplier <= w_mag2;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_sum;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_result <= w_res;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed bench for seq_mul_unit: results, latency, handshake and async reset.
module tb_seq_mul_unit;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned STEP_BITS = 1;
  localparam int unsigned N         = XLEN / STEP_BITS;
  localparam int          BOUND     = N + 20;
  localparam int          RST_AT    = (N > 10) ? 10 : N - 1;
`ifdef SEQ_MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_start;
  logic [1:0]      i_op;
  logic [XLEN-1:0] i_operand1;
  logic [XLEN-1:0] i_operand2;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mul_unit #(
    .XLEN     (XLEN),
    .STEP_BITS(STEP_BITS)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_op      (i_op),
    .i_operand1(i_operand1),
    .i_operand2(i_operand2),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_result  (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Cycles from the accepting edge to the edge at which done is first captured.
  function automatic int exp_lat(logic [1:0] op, logic [31:0] b);
    logic [31:0] m;
    int          k;
    m = (op == 2'b01 && b[31]) ? (~b + 32'd1) : b;
    k = 1;
    m = m >> STEP_BITS;
    while (m != 0) begin
      m = m >> STEP_BITS;
      k++;
    end
    return EARLY ? k + 2 : int'(N) + 2;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    i_op       = op;
    i_operand1 = a;
    i_operand2 = b;
    i_start    = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    check_eq("busy_on", 32'(o_busy), 32'd1);
  endtask

  task automatic wait_done(input int already, output int lat);
    int cycles;
    cycles = already;
    while (!o_done && cycles < BOUND) begin
      @(posedge i_clk);
      #1;
      cycles++;
    end
    lat = o_done ? cycles + 1 : 0;
  endtask

  task automatic run_vec(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int lat;
    launch(op, a, b);
    wait_done(0, lat);
    check_eq({tag, "_res"}, o_result, exp);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat(op, b)));
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    @(posedge i_clk);
    #1;
    check_eq({tag, "_pulse"}, 32'(o_done), 32'd0);
    check_eq({tag, "_hold"}, o_result, exp);
  endtask

  initial begin
    int          lat;
    int          d;
    int          n_done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_op       = 2'b00;
    i_operand1 = '0;
    i_operand2 = '0;
    #12;
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_result", o_result, 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    run_vec("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A);
    run_vec("mulh_m1m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run_vec("mulhu_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_vec("mulhsu_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_vec("mul_min", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_vec("mulh_minmin", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
    run_vec("mulh_minmax", 2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000);
    run_vec("mulhsu_min", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_vec("mulh_m2x3", 2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
    run_vec("mulh_maxmax", 2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF);
    run_vec("mul_shift", 2'b00, 32'h12345678, 32'h10, 32'h23456780);
    run_vec("mulhu_carry", 2'b11, 32'h80000000, 32'd2, 32'h00000001);
    run_vec("mul_zero", 2'b00, 32'd0, 32'hFFFFFFFF, 32'h00000000);
    run_vec("mul_3x2", 2'b00, 32'd3, 32'd2, 32'h00000006);

    // Start pulses and operand/op changes while busy must not disturb the result.
    launch(2'b00, 32'h1234, 32'h5678);
    d = exp_lat(2'b00, 32'h5678) - 2;
    if (d > 3) d = 3;
    for (int j = 0; j < d; j++) begin
      i_start    = 1'b1;
      i_op       = 2'b11;
      i_operand1 = 32'hFFFFFFFF;
      i_operand2 = 32'hFFFFFFFF;
      @(posedge i_clk);
      #1;
    end
    i_start = 1'b0;
    wait_done(d, lat);
    check_eq("busy_ign_res", o_result, 32'h06260060);
    check_eq("busy_ign_lat", 32'(lat), 32'(exp_lat(2'b00, 32'h5678)));

    // Back-to-back: issue on the done cycle.
    @(posedge i_clk);
    #1;
    launch(2'b00, 32'h11, 32'h2);
    wait_done(0, lat);
    check_eq("b2b_first_res", o_result, 32'h00000022);
    check_eq("b2b_done_cycle", 32'(o_done), 32'd1);
    launch(2'b00, 32'd3, 32'd5);
    wait_done(0, lat);
    check_eq("b2b_second_res", o_result, 32'h0000000F);
    check_eq("b2b_second_lat", 32'(lat), 32'(exp_lat(2'b00, 32'd5)));
    @(posedge i_clk);
    #1;

    // Asynchronous reset mid-CALC abandons the operation.
    launch(2'b00, 32'h1234, 32'hFFFFFFFF);
    for (int j = 0; j < RST_AT; j++) @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(o_busy), 32'd0);
    check_eq("arst_done", 32'(o_done), 32'd0);
    check_eq("arst_result", o_result, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst  = 1'b0;
    n_done = 0;
    for (int j = 0; j < int'(N) + 4; j++) begin
      @(posedge i_clk);
      #1;
      if (o_done) n_done++;
    end
    check_eq("arst_no_done", 32'(n_done), 32'd0);
    run_vec("post_rst", 2'b00, 32'd7, 32'd6, 32'h0000002A);

    for (int i = 0; i < 100; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
      launch(rop, ra, rb);
      wait_done(0, lat);
      check_eq($sformatf("rand%0d_res", i), o_result, ref_mul(rop, ra, rb));
      check_eq($sformatf("rand%0d_lat", i), 32'(lat), 32'(exp_lat(rop, rb)));
      @(posedge i_clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
